mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width driven to memory (256 words).
REQ-002 Parameter STARVE_MAX, default 4: consecutive denied instruction cycles before forced instruction grant.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  instruction-fetch read request; i_addr  input  32  byte address.
REQ-006 i_gnt  output  1  instruction request accepted this cycle; i_rvalid  output  1  fetch data valid; i_rdata  output  32  fetch data.
REQ-007 d_req  input  1  data request; d_we  input  1  1=write, 0=read; d_addr  input  32  byte address; d_wdata  input  32  write data.
REQ-008 d_gnt  output  1  data request accepted; d_rvalid  output  1  load data valid; d_rdata  output  32  load data.
REQ-009 m_read  output  1; m_write  output  1; m_addr  output  ADDR_W  word address; m_wdata  output  32; m_rdata  input  32 (shared memory, registered read, 1-cycle latency).

Function
REQ-010 Grant SHALL be combinational in the request cycle; at most one of i_gnt/d_gnt high per cycle.
REQ-011 Requester SHALL hold req, addr, we, wdata stable until gnt; arbiter SHALL NOT drop a held request.
REQ-012 m_addr SHALL equal granted addr[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 ignored.
REQ-013 Granted read: m_read=1 in grant cycle N; owner rvalid=1 in cycle N+1 only; rdata=m_rdata passthrough.
REQ-014 Granted write: m_write=1, m_wdata=d_wdata in cycle N; no d_rvalid generated.
REQ-015 Back-to-back grants every cycle SHALL be supported (one access per cycle, full throughput).
REQ-016 Registered read-owner state: IDLE, PEND_I, PEND_D; next state from grant in cycle N; rvalid decoded from state.
REQ-017 Default policy: d_req has priority over i_req.
REQ-018 Starvation counter increments each cycle i_req=1 and i_gnt=0, saturating at STARVE_MAX; clears on i_gnt or i_req=0.
REQ-019 When counter==STARVE_MAX and i_req=1, instruction SHALL win that cycle regardless of d_req.
REQ-020 No request: m_read=m_write=0, state returns to IDLE next cycle; m_addr/m_wdata don't-care.
REQ-021 i_rdata/d_rdata outside rvalid are don't-care; bench SHALL NOT check them.

Reset
REQ-022 rst_n low SHALL force i_gnt, d_gnt, m_read, m_write, i_rvalid, d_rvalid to 0 immediately, state to IDLE, counter to 0.
REQ-023 Reset mid-read SHALL drop the pending rvalid; no rvalid in first cycle after release.
REQ-024 First grant possible in first rising edge cycle after rst_n deasserts.

Configuration
REQ-025 Macro MEM_ARB_RR_EN defined: round-robin policy; registered last-winner bit, contended cycle grants the requester not granted last; starvation counter removed.
REQ-026 MEM_ARB_RR_EN undefined: REQ-017..REQ-019 fixed-priority-with-starvation policy.
REQ-027 Both builds SHALL share identical ports and timing.

Structure
REQ-028 Shared package cpu_pkg SHALL hold owner-state enum (IDLE, PEND_I, PEND_D) and word-size constant 32.
REQ-029 One sub-module, arb_pick, SHALL hold the combinational policy (priority/starvation or round-robin selection); mem_arbiter holds state, counter and muxing.

Verification
REQ-030 i_req only, i_addr=0x10 -> i_gnt same cycle, m_read=1, m_addr=0x04; cycle+1 i_rvalid=1, i_rdata=mem[4].
REQ-031 d_req, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, then d read 0x20 -> m_write at m_addr=0x08; later d_rvalid with 0xDEADBEEF, no d_rvalid on write cycle.
REQ-032 i_req and d_req held continuously (fixed build, STARVE_MAX=4) -> 4 d_gnt cycles, then 1 i_gnt, pattern repeats.
REQ-033 Same contention with MEM_ARB_RR_EN -> grants alternate d,i,d,i starting with d after reset.
REQ-034 Grant i read at cycle N, assert rst_n=0 in cycle N+1 before edge -> i_rvalid=0, all outputs 0, state IDLE.
REQ-035 i reads to 0x00,0x04,0x08 on consecutive cycles -> i_rvalid high three consecutive cycles, data mem[0],mem[1],mem[2] in order.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : shared types and constants for the memory arbiter slice
// Revision : 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int WORD_W = 32;

    // Which requester owns the read data returning in the following cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND_I = 2'd1,
        PEND_D = 2'd2
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter_if : instruction, data and memory buses of the arbiter
// Revision : 1.0
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 8
);
    import cpu_pkg::*;

    logic              i_req;
    logic [WORD_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [WORD_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [WORD_W-1:0] d_rdata;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [WORD_W-1:0] m_wdata;
    logic [WORD_W-1:0] m_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_read, m_write, m_addr, m_wdata
    );

    // Requesters plus memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
               m_read, m_write, m_addr, m_wdata
    );

endinterface
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_pick : combinational grant selection between instruction and data
//            MEM_ARB_RR_EN selects round-robin instead of fixed priority.
// Revision : 1.0
// ---------------------------------------------------------------------------
module arb_pick (
    input  wire  i_req,
    input  wire  d_req,
`ifdef MEM_ARB_RR_EN
    input  wire  last_i,
`else
    input  wire  starve_hit,
`endif
    output logic pick_i,
    output logic pick_d
);

`ifdef MEM_ARB_RR_EN
    // Under contention the requester that did not win last time goes next.
    assign pick_i = i_req & (~d_req | ~last_i);
`else
    // Data wins by default; a starved fetch overrides it for one cycle.
    assign pick_i = i_req & (~d_req | starve_hit);
`endif
    assign pick_d = d_req & ~pick_i;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : shares one single-port memory between fetch and load/store.
//               Define MEM_ARB_RR_EN for round-robin arbitration.
// Revision : 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input wire           clk,
    input wire           rst_n,
    mem_arbiter_if.slave bus
);

    owner_e state_q, state_d;
    logic   pick_i, pick_d;
    logic   gnt_i, gnt_d;

`ifdef MEM_ARB_RR_EN
    logic last_i_q, last_i_d;
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX != 0);
`else
    localparam int              CNT_W        = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starve_hit;
    assign starve_hit = (cnt_q == C_STARVE_MAX);
`endif

    arb_pick u_pick (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
`ifdef MEM_ARB_RR_EN
        .last_i     (last_i_q),
`else
        .starve_hit (starve_hit),
`endif
        .pick_i     (pick_i),
        .pick_d     (pick_d)
    );

    // Grants are combinational, so reset must mask them directly.
    assign gnt_i = pick_i & rst_n;
    assign gnt_d = pick_d & rst_n;

    always_comb begin
        state_d = IDLE;
        if (gnt_i) begin
            state_d = PEND_I;
        end else if (gnt_d && !bus.d_we) begin
            state_d = PEND_D;
        end
`ifdef MEM_ARB_RR_EN
        last_i_d = last_i_q;
        if (gnt_i) begin
            last_i_d = 1'b1;
        end else if (gnt_d) begin
            last_i_d = 1'b0;
        end
`else
        cnt_d = '0;
        if (bus.i_req && !gnt_i) begin
            cnt_d = starve_hit ? cnt_q : cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
`ifdef MEM_ARB_RR_EN
            // Pretend fetch won last so the first contended cycle goes to data.
            last_i_q <= 1'b1;
`else
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
`ifdef MEM_ARB_RR_EN
            last_i_q <= last_i_d;
`else
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.i_gnt    = gnt_i;
    assign bus.d_gnt    = gnt_d;
    assign bus.m_read   = gnt_i | (gnt_d & ~bus.d_we);
    assign bus.m_write  = gnt_d & bus.d_we;
    assign bus.m_addr   = gnt_d ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
    assign bus.m_wdata  = bus.d_wdata;
    assign bus.i_rvalid = (state_q == PEND_I);
    assign bus.d_rvalid = (state_q == PEND_D);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_addr[WORD_W-1:ADDR_W+2], bus.i_addr[1:0],
                                bus.d_addr[WORD_W-1:ADDR_W+2], bus.d_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed table-driven bench for mem_arbiter
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(8)) bus ();

    mem_arbiter #(.ADDR_W(8), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: unwritten word k reads as 0xA0000000 + k.
    logic [31:0] wmem [256];
    bit   [255:0] wflag;
    always @(posedge clk) begin
        if (bus.m_write) begin
            wmem[bus.m_addr]  <= bus.m_wdata;
            wflag[bus.m_addr] <= 1'b1;
        end
        if (bus.m_read) begin
            bus.m_rdata <= wflag[bus.m_addr] ? wmem[bus.m_addr]
                                             : (32'hA000_0000 | 32'(bus.m_addr));
        end
    end

    typedef struct packed {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_igt;
        logic        e_dgt;
        logic        e_rd;
        logic        e_wr;
        logic [7:0]  e_addr;
        logic        e_irv;
        logic        e_drv;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic we, input logic [31:0] da, input logic [31:0] dw);
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = we;
        bus.d_addr  = da;
        bus.d_wdata = dw;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_i;
        logic prev_i;

        //          ireq iaddr          dreq we daddr      dwdata          igt dgt rd wr addr   irv drv rdata
        vecs[0]  = '{1'b1, 32'h10,       1'b0, 1'b0, 32'h0,  32'h0,        1'b1,1'b0,1'b1,1'b0,8'h04,1'b0,1'b0,32'h0};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,32'hA000_0004};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0,1'b1,1'b0,1'b1,8'h08,1'b0,1'b0,32'h0};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h20, 32'h0,        1'b0,1'b1,1'b1,1'b0,8'h08,1'b0,1'b0,32'h0};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b1,32'hDEADBEEF};
        vecs[5]  = '{1'b1, 32'h00,       1'b0, 1'b0, 32'h0,  32'h0,        1'b1,1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,32'h0};
        vecs[6]  = '{1'b1, 32'h04,       1'b0, 1'b0, 32'h0,  32'h0,        1'b1,1'b0,1'b1,1'b0,8'h01,1'b1,1'b0,32'hA000_0000};
        vecs[7]  = '{1'b1, 32'h08,       1'b0, 1'b0, 32'h0,  32'h0,        1'b1,1'b0,1'b1,1'b0,8'h02,1'b1,1'b0,32'hA000_0001};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,32'hA000_0002};
        vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,32'h0};
        vecs[10] = '{1'b1, 32'hABCD_E3FE,1'b0, 1'b0, 32'h0,  32'h0,        1'b1,1'b0,1'b1,1'b0,8'hFF,1'b0,1'b0,32'h0};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,32'hA000_00FF};
        vecs[12] = '{1'b1, 32'h40,       1'b1, 1'b0, 32'h0C, 32'h0,        1'b0,1'b1,1'b1,1'b0,8'h03,1'b0,1'b0,32'h0};
        vecs[13] = '{1'b1, 32'h40,       1'b0, 1'b0, 32'h0,  32'h0,        1'b1,1'b0,1'b1,1'b0,8'h10,1'b0,1'b1,32'hA000_0003};
        vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,        1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,32'hA000_0010};

        // Reset with both requests asserted: everything must stay low.
        rst_n = 1'b0;
        drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
        @(posedge clk);
        @(negedge clk);
        chk("reset i_gnt",    32'(bus.i_gnt),    32'd0);
        chk("reset d_gnt",    32'(bus.d_gnt),    32'd0);
        chk("reset m_read",   32'(bus.m_read),   32'd0);
        chk("reset m_write",  32'(bus.m_write),  32'd0);
        chk("reset i_rvalid", 32'(bus.i_rvalid), 32'd0);
        chk("reset d_rvalid", 32'(bus.d_rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < NVEC; v++) begin
            drive(vecs[v].i_req, vecs[v].i_addr, vecs[v].d_req,
                  vecs[v].d_we, vecs[v].d_addr, vecs[v].d_wdata);
            @(negedge clk);
            chk($sformatf("v%0d i_gnt", v),    32'(bus.i_gnt),    32'(vecs[v].e_igt));
            chk($sformatf("v%0d d_gnt", v),    32'(bus.d_gnt),    32'(vecs[v].e_dgt));
            chk($sformatf("v%0d m_read", v),   32'(bus.m_read),   32'(vecs[v].e_rd));
            chk($sformatf("v%0d m_write", v),  32'(bus.m_write),  32'(vecs[v].e_wr));
            chk($sformatf("v%0d i_rvalid", v), 32'(bus.i_rvalid), 32'(vecs[v].e_irv));
            chk($sformatf("v%0d d_rvalid", v), 32'(bus.d_rvalid), 32'(vecs[v].e_drv));
            if (vecs[v].e_rd || vecs[v].e_wr)
                chk($sformatf("v%0d m_addr", v), 32'(bus.m_addr), 32'(vecs[v].e_addr));
            if (vecs[v].e_wr)
                chk($sformatf("v%0d m_wdata", v), bus.m_wdata, vecs[v].d_wdata);
            if (vecs[v].e_irv)
                chk($sformatf("v%0d i_rdata", v), bus.i_rdata, vecs[v].e_rdata);
            if (vecs[v].e_drv)
                chk($sformatf("v%0d d_rdata", v), bus.d_rdata, vecs[v].e_rdata);
            @(posedge clk);
            #1;
        end

        // Continuous contention from a fresh reset.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h0C, 32'h0);
        prev_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_i = (k % 2 == 1);
`else
            exp_i = (k % 5 == 4);
`endif
            @(negedge clk);
            chk($sformatf("cont%0d i_gnt", k), 32'(bus.i_gnt), 32'(exp_i));
            chk($sformatf("cont%0d d_gnt", k), 32'(bus.d_gnt), 32'(!exp_i));
            if (k > 0) begin
                chk($sformatf("cont%0d i_rvalid", k), 32'(bus.i_rvalid), 32'(prev_i));
                chk($sformatf("cont%0d d_rvalid", k), 32'(bus.d_rvalid), 32'(!prev_i));
            end
            prev_i = exp_i;
            @(posedge clk);
            #1;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;

        // Reset arriving while a fetch read is pending.
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rmid grant i_gnt", 32'(bus.i_gnt), 32'd1);
        @(posedge clk);
        #1;
        drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h5555_AAAA);
        chk("rmid pending i_rvalid", 32'(bus.i_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmid i_rvalid", 32'(bus.i_rvalid), 32'd0);
        chk("rmid d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rmid i_gnt",    32'(bus.i_gnt),    32'd0);
        chk("rmid d_gnt",    32'(bus.d_gnt),    32'd0);
        chk("rmid m_read",   32'(bus.m_read),   32'd0);
        chk("rmid m_write",  32'(bus.m_write),  32'd0);
        @(posedge clk);
        #1;
        chk("rhold i_rvalid", 32'(bus.i_rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rrel i_rvalid", 32'(bus.i_rvalid), 32'd0);
        chk("rrel d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rrel i_gnt",    32'(bus.i_gnt),    32'd1);
        chk("rrel m_addr",   32'(bus.m_addr),   32'h05);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rrel next i_rvalid", 32'(bus.i_rvalid), 32'd1);
        chk("rrel next i_rdata",  bus.i_rdata,       32'hA000_0005);
        chk("rrel next d_rvalid", 32'(bus.d_rvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
